branch_predict_unit: RTL

//  Dynamic branch predictor for the next-generation pipelined CPU: direct-mapped BTB with
//  per-entry 2-bit saturating counters. Looked up combinationally with the IF-stage PC to choose
//  the next PC; trained by the resolving branch in MEM. Cuts the fixed 3-instruction flush on

---
 rtl/branch_predict_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Direct-mapped BTB with 2-bit saturating counters, combinational
//               lookup, MEM-stage training and branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] correct_pc_o,
    input  logic              clr_stats_i,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic [ENTRIES-1:0] w_valid;
    logic [TAG_W-1:0]   w_tag    [ENTRIES];
    logic [ADDR_W-1:0]  w_target [ENTRIES];
    logic [1:0]         w_ctr    [ENTRIES];

    logic [IDX_W-1:0]   w_lk_idx;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic [1:0]         w_ctr_step;

    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

    assign w_lk_idx = lookup_pc_i[IDX_W+1:2];
    assign w_lk_tag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_up_idx = upd_pc_i[IDX_W+1:2];
    assign w_up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup sees only registered state: an update to the same entry shows up next cycle.
    assign pred_hit_o    = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken_o  = pred_hit_o && w_ctr[w_lk_idx][1];
    assign pred_target_o = pred_taken_o ? w_target[w_lk_idx] : lookup_pc_i + ADDR_W'(4);

    assign w_up_hit = w_valid[w_up_idx] && (w_tag[w_up_idx] == w_up_tag);

    always_comb begin
        w_ctr_step = w_ctr[w_up_idx];
        case (w_ctr[w_up_idx])
            CTR_SNT: w_ctr_step = upd_taken_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: w_ctr_step = upd_taken_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  w_ctr_step = upd_taken_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  w_ctr_step = upd_taken_i ? CTR_ST  : CTR_WT;
            default: w_ctr_step = CTR_WNT;
        endcase
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic              sel_w;
        logic              valid_q;
        logic [TAG_W-1:0]  tag_q;
        logic [ADDR_W-1:0] target_q;
        logic [1:0]        ctr_q;

        assign sel_w = upd_valid_i && (w_up_idx == IDX_W'(i));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q  <= 1'b0;
                tag_q    <= '0;
                target_q <= '0;
                ctr_q    <= CTR_WNT;
            end else if (sel_w) begin
                if (w_up_hit) begin
                    ctr_q <= w_ctr_step;
                    if (upd_taken_i) begin
                        target_q <= upd_target_i;
                    end
                end else if (upd_taken_i) begin
                    valid_q  <= 1'b1;
                    tag_q    <= w_up_tag;
                    target_q <= upd_target_i;
                    ctr_q    <= CTR_WT;
                end
            end
        end

        assign w_valid[i]  = valid_q;
        assign w_tag[i]    = tag_q;
        assign w_target[i] = target_q;
        assign w_ctr[i]    = ctr_q;
    end

    assign mispredict_o = upd_valid_i &&
                          ((upd_pred_taken_i != upd_taken_i) ||
                           (upd_taken_i && (upd_pred_target_i != upd_target_i)));
    assign correct_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);

    // Clear has priority over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (clr_stats_i) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else begin
            if (upd_valid_i && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (mispredict_o && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule
`default_nettype wire
